// File: rtl/sd_sector_arbiter.sv
// Two-port sector arbiter in front of one SPI-mode SD controller.
// Define SD_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module sd_sector_arbiter #(
    parameter int unsigned BLOCK_BYTES = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [7:0]  din0,
    input  logic [7:0]  din1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        dreq0,
    output logic        dreq1,
    output logic        dvalid0,
    output logic        dvalid1,
    output logic [7:0]  rdata,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic        busy,
    input  logic        sd_ready,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic [31:0] sd_address,
    output logic [7:0]  sd_din,
    input  logic [7:0]  sd_dout,
    input  logic        sd_byte_available,
    input  logic        sd_ready_for_next_byte
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] XFER      = 3'd3;
    localparam logic [2:0] FINISH    = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        id_q, id_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        bavail_q, rfnb_q;
    logic        dvalid0_q, dvalid0_d, dvalid1_q, dvalid1_d;
    logic        dreq0_q, dreq0_d, dreq1_q, dreq1_d;
    logic        done0_q, done0_d, done1_q, done1_d;
    logic        err_q, err_d;
    logic        busy_q;
`ifdef SD_ARB_RR_EN
    logic        ptr_q, ptr_d;
`endif

    logic        arb_go, win, win_we;
    logic [31:0] win_addr;
    logic        rd_edge, wr_edge;

    always_comb begin
        // No arbitration in a done cycle: the requester still holds req there.
        arb_go   = (state_q == IDLE) && sd_ready && (req0 || req1) && !(done0_q || done1_q);
`ifdef SD_ARB_RR_EN
        win      = (req0 && req1) ? ptr_q : req1;
`else
        win      = !req0;
`endif
        win_we   = win ? we1 : we0;
        win_addr = win ? addr1 : addr0;
        rd_edge  = sd_byte_available && !bavail_q;
        wr_edge  = sd_ready_for_next_byte && !rfnb_q;

        state_d   = state_q;
        id_d      = id_q;
        we_d      = we_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        dvalid0_d = 1'b0;
        dvalid1_d = 1'b0;
        dreq0_d   = 1'b0;
        dreq1_d   = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        err_d     = 1'b0;
`ifdef SD_ARB_RR_EN
        ptr_d     = ptr_q;
`endif

        case (state_q)
            IDLE: begin
                if (arb_go) begin
                    if (win_addr[8:0] != 9'd0) begin
                        done0_d = !win;
                        done1_d = win;
                        err_d   = 1'b1;
                    end else begin
                        id_d    = win;
                        we_d    = win_we;
                        addr_d  = win_addr;
                        cnt_d   = '0;
                        state_d = ISSUE;
`ifdef SD_ARB_RR_EN
                        ptr_d   = !win;
`endif
                    end
                end
            end
            ISSUE:     state_d = sd_ready ? WAIT_BUSY : XFER;
            WAIT_BUSY: if (!sd_ready) state_d = XFER;
            XFER: begin
                if (rd_edge) begin
                    rdata_d   = sd_dout;
                    dvalid0_d = !id_q;
                    dvalid1_d = id_q;
                    if (cnt_q != 10'd1023) cnt_d = cnt_q + 10'd1;
                end
                if (wr_edge) begin
                    dreq0_d = !id_q;
                    dreq1_d = id_q;
                end
                if (sd_ready) begin
                    // Use cnt_d so a byte arriving in the final cycle still counts.
                    done0_d = !id_q;
                    done1_d = id_q;
                    err_d   = !we_q && (cnt_d != 10'(BLOCK_BYTES));
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            id_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            bavail_q  <= 1'b0;
            rfnb_q    <= 1'b0;
            dvalid0_q <= 1'b0;
            dvalid1_q <= 1'b0;
            dreq0_q   <= 1'b0;
            dreq1_q   <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SD_ARB_RR_EN
            ptr_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            bavail_q  <= sd_byte_available;
            rfnb_q    <= sd_ready_for_next_byte;
            dvalid0_q <= dvalid0_d;
            dvalid1_q <= dvalid1_d;
            dreq0_q   <= dreq0_d;
            dreq1_q   <= dreq1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err_q     <= err_d;
            busy_q    <= (state_d != IDLE);
`ifdef SD_ARB_RR_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign gnt0       = (state_q != IDLE) && !id_q;
    assign gnt1       = (state_q != IDLE) && id_q;
    assign sd_rd      = ((state_q == ISSUE) || (state_q == WAIT_BUSY)) && !we_q;
    assign sd_wr      = ((state_q == ISSUE) || (state_q == WAIT_BUSY)) && we_q;
    assign sd_din     = gnt0 ? din0 : (gnt1 ? din1 : 8'hFF);
    assign sd_address = addr_q;
    assign rdata      = rdata_q;
    assign dvalid0    = dvalid0_q;
    assign dvalid1    = dvalid1_q;
    assign dreq0      = dreq0_q;
    assign dreq1      = dreq1_q;
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign err        = err_q;
    assign busy       = busy_q;

endmodule
